// File: rtl/fetch_pc_if.sv
// Fetch-stage PC control bundle: decode/control events in, PC and status out.
interface fetch_pc_if;
    localparam int unsigned PC_W = 16;

    logic            halt;
    logic            exception;
    logic            rti;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            stall;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inc_pc;
    logic [PC_W-1:0] epc;
    logic            imem_en;
    logic            in_handler;
    logic            halted;
    logic            exc_dropped;

    modport master (
        output halt, exception, rti, redirect, redirect_pc, stall,
        input  pc, inc_pc, epc, imem_en, in_handler, halted, exc_dropped
    );

    modport slave (
        input  halt, exception, rti, redirect, redirect_pc, stall,
        output pc, inc_pc, epc, imem_en, in_handler, halted, exc_dropped
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program-counter sequencer: prioritised next-PC selection with
// exception entry/return, stall and halt.
module fetch_pc_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.slave  bus
);
    localparam int unsigned PC_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        HANDLER = 2'b01,
        HALTED  = 2'b10
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] epc;
    logic            exc_dropped;
    logic [PC_W-1:0] inc_pc;
    logic [PC_W-1:0] target_pc;

    assign inc_pc    = pc + PC_W'(2);
    assign target_pc = bus.redirect_pc & PC_W'(16'hFFFE);

    // Single state machine owning pc, epc and the dropped-exception pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            epc         <= '0;
            exc_dropped <= 1'b0;
        end else begin
            exc_dropped <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.halt) begin
                        state <= HALTED;
                    end else if (bus.exception) begin
                        epc   <= inc_pc;
                        pc    <= EXC_VECTOR;
                        state <= HANDLER;
                    end else if (bus.rti) begin
                        pc <= inc_pc;
                    end else if (bus.redirect) begin
                        pc <= target_pc;
                    end else if (!bus.stall) begin
                        pc <= inc_pc;
                    end
                end
                HANDLER: begin
                    if (bus.halt) begin
                        state <= HALTED;
                    end else begin
                        // Exceptions do not nest; flag the loss and carry on.
                        if (bus.exception) begin
                            exc_dropped <= 1'b1;
                        end
                        if (bus.rti) begin
                            pc    <= epc;
                            state <= RUN;
                        end else if (bus.redirect) begin
                            pc <= target_pc;
                        end else if (!bus.stall) begin
                            pc <= inc_pc;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                    pc    <= RESET_PC;
                end
            endcase
        end
    end

    assign bus.pc          = pc;
    assign bus.inc_pc      = inc_pc;
    assign bus.epc         = epc;
    assign bus.exc_dropped = exc_dropped;
    assign bus.imem_en     = (state != HALTED);
    assign bus.in_handler  = (state == HANDLER);
    assign bus.halted      = (state == HALTED);
endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Program-counter sequencer for the fetch stage. Owns the PC and EPC registers and chooses, each cycle, between sequential increment, branch/jump redirect, stall, exception entry, return-from-exception and halt. It drives the instruction-memory address and enable, and exports the incremented PC for link/writeback use. It replaces ad-hoc next-PC muxing in fetch with one prioritised state machine.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- EXC_VECTOR, 16'h0002, PC loaded on exception entry

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- halt  in  1  HALT instruction decoded this cycle
- exception  in  1  exception raised by the current instruction
- rti  in  1  return-from-exception decoded this cycle
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  16  branch/jump target
- stall  in  1  hold PC (hazard/memory busy)
- pc  out  16  current PC; instruction-memory address
- inc_pc  out  16  pc + 2, combinational
- epc  out  16  saved return address
- imem_en  out  1  instruction-memory read enable
- in_handler  out  1  1 while executing the exception handler
- halted  out  1  1 once halted
- exc_dropped  out  1  one-cycle pulse: exception ignored while in the handler

## Operation
- States: RUN (00), HANDLER (01), HALTED (10). Encoding 11 is unused and recovers to RUN on the next edge with pc <= RESET_PC.
- Per-edge priority, highest first: halt > exception > rti > redirect > stall > increment.
- RUN:
  - halt: go to HALTED; pc holds.
  - exception: epc <= inc_pc; pc <= EXC_VECTOR; go to HANDLER.
  - rti: ignored; treated as increment.
  - redirect: pc <= {redirect_pc[15:1], 1'b0}.
  - stall: pc holds.
  - otherwise: pc <= inc_pc.
- HANDLER:
  - halt: go to HALTED.
  - exception: not nested. exc_dropped pulses for one cycle; epc is unchanged; pc follows the lower-priority rules.
  - rti: pc <= epc; go to RUN.
  - redirect, stall and increment behave as in RUN.
- HALTED: pc, epc and state are frozen. Every input is ignored. Exit only through rst.
- Arithmetic: inc_pc = pc + 16'd2, modulo 2^16, so 16'hFFFE wraps to 16'h0000. No carry-out.
- Bit 0 of pc is always 0. RESET_PC and EXC_VECTOR must be even.
- imem_en = (state != HALTED).
- in_handler = (state == HANDLER).
- halted = (state == HALTED).

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk):
  - pc = RESET_PC, epc = 16'h0000, state = RUN
  - in_handler = 0, halted = 0, exc_dropped = 0, imem_en = 1
- Control inputs are sampled on the rising edge. pc, epc and state update on that same edge, giving one-cycle latency from input to new pc.
- inc_pc, imem_en, in_handler and halted are combinational from the registered state and pc. There is no input-to-output combinational path.
- exc_dropped is registered: high for exactly the cycle after the ignored exception edge.
- Inputs held across several edges are re-evaluated every edge. For example, a continuous stall keeps pc constant indefinitely.
- Simultaneous events:
  - exception + stall: exception wins.
  - exception + redirect: exception wins; epc = inc_pc, not redirect_pc.
  - rti + redirect in HANDLER: rti wins.
  - halt + anything: halt wins.
- rst asserted mid-handler: state returns to RUN and epc clears to 0. The handler is abandoned.

## Test plan
- Reset and increment: rst pulse, then 3 free edges → pc = 0000, 0002, 0004, 0006; imem_en = 1; epc = 0000.
- Exception round trip: at pc = 0010 assert exception for 1 cycle → pc = 0002, epc = 0012, in_handler = 1. Increment to 0006, then assert rti → pc = 0012, in_handler = 0.
- Nested exception: in HANDLER at pc = 0004 assert exception → exc_dropped pulses 1 cycle, epc unchanged, pc = 0006.
- Priority: assert exception + redirect (redirect_pc = 0100) + stall at pc = 0020 → pc = 0002, epc = 0022. Separately, redirect_pc = 0101 with no other event → pc = 0100.
- Halt: assert halt at pc = 0030 → halted = 1, imem_en = 0. pc stays 0030 for 5 edges despite redirect, exception and rti. Asynchronous rst between edges → pc = 0000, halted = 0 immediately.
- Wrap: redirect to FFFE, then 1 free edge → pc = 0000 and inc_pc = 0002. An exception at FFFE gives epc = 0000.
